// File: rtl/data_mem_sized_if.sv
// Request/response bundle for the sized data memory.
// Master issues loads/stores; slave returns registered responses.
interface data_mem_sized_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_write;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              fault;
    logic              busy;

    modport master (
        output req_valid, req_write, funct3, addr, wdata,
        input  ready, rdata, rvalid, fault, busy
    );

    modport slave (
        input  req_valid, req_write, funct3, addr, wdata,
        output ready, rdata, rvalid, fault, busy
    );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressable RV32I data memory with sized access, faults,
// one-cycle registered reads and a post-reset clear engine.
module data_mem_sized #(
    parameter int ADDR_W         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_sized_if.slave  bus
);
    localparam int IW    = ADDR_W - 2;
    localparam int DEPTH = 1 << IW;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_q;

    logic            acc;
    logic            is_b, is_h, is_w;
    logic            code_ok, misal, ok;
    logic [3:0]      st_mask;
    logic            we;
    logic [3:0]      wmask;
    logic [IW-1:0]   widx;
    logic [31:0]     wword;
    logic [IW-1:0]   ridx;

    logic            rvalid_q, fault_q, zero_q;
    logic [1:0]      lane_q;
    logic [2:0]      f3_q;
    logic [31:0]     shifted;
    logic [31:0]     ext;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN:     ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready = (state_q == RUN);
    assign bus.busy  = (state_q == CLEAR);
    assign acc       = bus.req_valid && bus.ready && !reset;

    always_comb begin
        is_b    = (bus.funct3[1:0] == 2'b00);
        is_h    = (bus.funct3[1:0] == 2'b01);
        is_w    = (bus.funct3 == 3'b010);
        code_ok = 1'b0;
        unique case (bus.funct3)
            3'b000, 3'b001, 3'b010: code_ok = 1'b1;
            3'b100, 3'b101:         code_ok = !bus.req_write;
            default:                code_ok = 1'b0;
        endcase
        misal = (is_h && bus.addr[0]) ||
                (is_w && (bus.addr[1:0] != 2'b00));
        ok    = code_ok && !misal;
        st_mask = 4'b0000;
        unique case (1'b1)
            is_w:    st_mask = 4'b1111;
            is_h:    st_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
            is_b:    st_mask = 4'b0001 << bus.addr[1:0];
            default: st_mask = 4'b0000;
        endcase
    end

    // The clear engine owns the single write port while busy.
    always_comb begin
        we    = 1'b0;
        wmask = st_mask;
        widx  = bus.addr[ADDR_W-1:2];
        wword = bus.wdata << {bus.addr[1:0], 3'b000};
        if (state_q == CLEAR) begin
            we    = !reset;
            wmask = 4'b1111;
            widx  = cnt_q;
            wword = '0;
        end else begin
            we = acc && bus.req_write && ok;
        end
    end

    assign ridx = bus.addr[ADDR_W-1:2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && wmask[i])
                mem[widx][8*i +: 8] <= wword[8*i +: 8];
        if (acc && !bus.req_write)
            rd_q <= mem[ridx];
    end

    // Response metadata only changes on acceptance, so rdata holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            zero_q   <= 1'b1;
            lane_q   <= 2'b00;
            f3_q     <= 3'b010;
        end else begin
            rvalid_q <= acc;
            fault_q  <= acc && !ok;
            if (acc) begin
                zero_q <= bus.req_write || !ok;
                lane_q <= bus.addr[1:0];
                f3_q   <= bus.funct3;
            end
        end
    end

    always_comb begin
        shifted = rd_q >> {lane_q, 3'b000};
        unique case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign bus.rdata  = zero_q ? 32'h0 : ext;
    assign bus.rvalid = rvalid_q;
    assign bus.fault  = fault_q;
endmodule

// File: tb/tb_data_mem_sized.sv
// Directed and model-checked test of data_mem_sized at ADDR_W=6.
// Covers clear timing, sized access, extension, faults and reset.
module tb_data_mem_sized;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] ref_m [64];

    data_mem_sized_if #(.ADDR_W(AW)) bus ();

    data_mem_sized #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic w, input logic [2:0] f3,
                       input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [31:0] d,
                        input logic f);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        check({tag, "_fault"}, 32'(bus.fault), 32'(f));
        check({tag, "_rdata"}, bus.rdata, d);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        reset = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.busy && n < 100);
        check({tag, "_cycles"}, n, 16);
        check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    endtask

    function automatic logic [31:0] exp_ld(input logic [2:0] f3,
                                           input int a);
        logic [31:0] w;
        w = {ref_m[(a & ~3) + 3], ref_m[(a & ~3) + 2],
             ref_m[(a & ~3) + 1], ref_m[a & ~3]};
        case (f3)
            3'b000: return {{24{ref_m[a][7]}}, ref_m[a]};
            3'b100: return {24'h0, ref_m[a]};
            3'b001: return {{16{ref_m[a+1][7]}}, ref_m[a+1], ref_m[a]};
            3'b101: return {16'h0, ref_m[a+1], ref_m[a]};
            default: return w;
        endcase
    endfunction

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.funct3    = 3'b010;
        bus.addr      = '0;
        bus.wdata     = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        wait_clear("clear");

        for (int i = 0; i < 16; i++) begin
            req(1'b0, 3'b010, AW'(i * 4), 32'h0);
            resp($sformatf("lw0_%0d", i), 32'h0, 1'b0);
        end
        idle();

        // Reset in the middle of a clear restarts it from word 0.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midclr_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        wait_clear("reclear");

        req(1'b1, 3'b010, 6'h08, 32'h11223344);
        resp("sw", 32'h0, 1'b0);
        req(1'b1, 3'b000, 6'h09, 32'h000000AA);
        resp("sb", 32'h0, 1'b0);
        req(1'b1, 3'b001, 6'h0A, 32'h0000BEEF);
        resp("sh", 32'h0, 1'b0);
        req(1'b0, 3'b010, 6'h08, 32'h0);
        resp("lw", 32'hBEEFAA44, 1'b0);
        req(1'b0, 3'b000, 6'h09, 32'h0);
        resp("lb", 32'hFFFFFFAA, 1'b0);
        req(1'b0, 3'b100, 6'h09, 32'h0);
        resp("lbu", 32'h000000AA, 1'b0);
        req(1'b0, 3'b001, 6'h0A, 32'h0);
        resp("lh", 32'hFFFFBEEF, 1'b0);
        req(1'b0, 3'b101, 6'h0A, 32'h0);
        resp("lhu", 32'h0000BEEF, 1'b0);
        req(1'b0, 3'b101, 6'h08, 32'h0);
        resp("lhu_lo", 32'h0000AA44, 1'b0);

        req(1'b1, 3'b010, 6'h0D, 32'hDEADBEEF);
        resp("sw_mis", 32'h0, 1'b1);
        req(1'b0, 3'b010, 6'h0C, 32'h0);
        resp("sw_mis_chk", 32'h0, 1'b0);
        req(1'b0, 3'b001, 6'h03, 32'h0);
        resp("lh_mis", 32'h0, 1'b1);
        req(1'b0, 3'b011, 6'h08, 32'h0);
        resp("ld_ill", 32'h0, 1'b1);
        req(1'b1, 3'b100, 6'h14, 32'h12345678);
        resp("st_ill", 32'h0, 1'b1);
        req(1'b0, 3'b010, 6'h14, 32'h0);
        resp("st_ill_chk", 32'h0, 1'b0);

        req(1'b1, 3'b010, 6'h10, 32'hCAFEF00D);
        resp("b2b_sw", 32'h0, 1'b0);
        req(1'b0, 3'b010, 6'h10, 32'h0);
        resp("b2b_lw", 32'hCAFEF00D, 1'b0);
        idle();
        @(posedge clk);
        #1;
        check("idle_rvalid", 32'(bus.rvalid), 32'd0);
        check("idle_hold", bus.rdata, 32'hCAFEF00D);

        // Random traffic from a freshly cleared array.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        wait_clear("clear3");
        for (int i = 0; i < 64; i++) ref_m[i] = 8'h0;
        for (int i = 0; i < 32; i++) begin
            logic        w;
            logic [2:0]  f3;
            int          a;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, w ? 2 : 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            a = int'($urandom_range(0, 63));
            if (f3[1:0] == 2'b01) a = a & ~1;
            if (f3 == 3'b010) a = a & ~3;
            d = $urandom;
            req(w, f3, AW'(a), d);
            if (w) begin
                ref_m[a] = d[7:0];
                if (f3 != 3'b000) ref_m[a+1] = d[15:8];
                if (f3 == 3'b010) begin
                    ref_m[a+2] = d[23:16];
                    ref_m[a+3] = d[31:24];
                end
                resp($sformatf("rnd_st%0d", i), 32'h0, 1'b0);
            end else begin
                resp($sformatf("rnd_ld%0d", i), exp_ld(f3, a), 1'b0);
            end
        end

        // A load accepted on a reset edge must not respond.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.funct3    = 3'b010;
        bus.addr      = 6'h10;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        check("rstld_rvalid", 32'(bus.rvalid), 32'd0);
        check("rstld_fault", 32'(bus.fault), 32'd0);
        check("rstld_rdata", bus.rdata, 32'h0);
        check("rstld_busy", 32'(bus.busy), 32'd1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
